fsm_code_lock: RTL

Parametrised Moore FSM that unlocks on a programmed sequence of input codes. It counts failed attempts and enters a timed lockout after too many failures. Any illegal state encoding recovers fail-secure to LOCKOUT. It generalises the fixed 3-bit, 4-state input/output FSM to configurable input width, sequence depth and timers, and sits between the user-input front end and the access-control logic.

---
 rtl/fsm_code_lock_if.sv | 27 ++
 rtl/fsm_code_lock.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fsm_code_lock_if.sv
// Bundle of the code-lock user-side inputs and status outputs.
// The master drives codes and control; the slave is the lock itself.
interface fsm_code_lock_if #(
   parameter int IN_W     = 3,
   parameter int DEPTH    = 3,
   parameter int MAX_FAIL = 3
);
   localparam int FC_W = $clog2(MAX_FAIL + 1);

   logic [IN_W-1:0]       user_input;
   logic                  in_valid;
   logic [DEPTH*IN_W-1:0] code;
   logic                  relock;
   logic [2:0]            out;
   logic                  unlock;
   logic [FC_W-1:0]       fail_cnt;

   modport master (
      output user_input, in_valid, code, relock,
      input  out, unlock, fail_cnt
   );

   modport slave (
      input  user_input, in_valid, code, relock,
      output out, unlock, fail_cnt
   );
endinterface

// File: rtl/fsm_code_lock.sv
// Sequence code lock: unlocks after DEPTH matching codes, counts consecutive
// failures and enters a timed lockout after MAX_FAIL of them.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for the first code of the sequence
//   MATCH   | part of the sequence entered, idx = next step to match
//   OPEN    | unlocked for OPEN_CYCLES cycles or until relock
//   LOCKOUT | too many failures (or corrupt state), inputs ignored
//   other   | illegal encoding, recovers to LOCKOUT (fail-secure)
module fsm_code_lock #(
   parameter int IN_W        = 3,
   parameter int DEPTH       = 3,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 8,
   parameter int OPEN_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   fsm_code_lock_if.slave     bus
);
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FC_W    = $clog2(MAX_FAIL + 1);
   localparam int TMR_MAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
   localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_FAIL - 1);
   localparam logic [TMR_W-1:0] TMR_LOCK = TMR_W'(LOCK_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_OPEN = TMR_W'(OPEN_CYCLES - 1);

   // Encoding doubles as the out status so out is a plain register copy.
   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      MATCH   = 3'b001,
      OPEN    = 3'b010,
      LOCKOUT = 3'b100
   } state_t;

   // Held as raw bits so any corrupted value is representable and recovered.
   logic [2:0]       state_q;
   state_t           state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [FC_W-1:0]  fail_q, fail_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   logic [IN_W-1:0]  exp_code;
   logic             code_hit;

   assign exp_code = bus.code[idx_q*IN_W +: IN_W];
   assign code_hit = (bus.user_input == exp_code);

   // State, step index, failure count and shared timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         fail_q  <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         fail_q  <= fail_d;
         tmr_q   <= tmr_d;
      end
   end

   // Next-state logic; IDLE and MATCH share the compare path since idx is 0 in IDLE.
   always_comb begin
      state_d = IDLE;
      idx_d   = idx_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q;
      case (state_q)
         IDLE, MATCH: begin
            state_d = (state_q == MATCH) ? MATCH : IDLE;
            if (bus.in_valid) begin
               if (code_hit) begin
                  if (idx_q == IDX_LAST) begin
                     state_d = OPEN;
                     idx_d   = '0;
                     fail_d  = '0;
                     tmr_d   = TMR_OPEN;
                  end else begin
                     state_d = MATCH;
                     idx_d   = idx_q + 1'b1;
                  end
               end else if (fail_q >= FC_LAST) begin
                  // >= rather than == keeps the count saturated at MAX_FAIL.
                  state_d = LOCKOUT;
                  idx_d   = '0;
                  fail_d  = FC_MAX;
                  tmr_d   = TMR_LOCK;
               end else begin
                  state_d = IDLE;
                  idx_d   = '0;
                  fail_d  = fail_q + 1'b1;
               end
            end
         end
         OPEN: begin
            state_d = OPEN;
            if (bus.relock || (tmr_q == '0)) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         LOCKOUT: begin
            state_d = LOCKOUT;
            if (tmr_q == '0) begin
               state_d = IDLE;
               fail_d  = '0;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: begin
            state_d = LOCKOUT;
            idx_d   = '0;
            fail_d  = FC_MAX;
            tmr_d   = TMR_LOCK;
         end
      endcase
   end

   assign bus.out      = state_q;
   assign bus.unlock   = (state_q == OPEN);
   assign bus.fail_cnt = fail_q;

endmodule
